// File: rtl/memory_btn_pkg.sv
// rtl/memory_btn_pkg.sv - shared encodings and navigation priority for the button conditioner
//
// Purpose: debounce FSM state encoding, button index map, and the priority
//          picker that chooses which pending navigation press issues next.
// Ports:   none (package).

package memory_btn_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WQ1   = 3'd1,
        S_PRESS = 3'd2,
        S_HELD  = 3'd3,
        S_WQ0   = 3'd4
    } btn_state_t;

    localparam int BTN_RIGHT  = 0;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_UP     = 2;
    localparam int BTN_DOWN   = 3;
    localparam int BTN_SELECT = 4;
    localparam int BTN_START  = 5;
    localparam int BTN_ACK    = 6;

    localparam int N_BTN = 7;
    localparam int N_NAV = 5;

    // One-hot pick of the highest-priority pending press.
    // Order: Select > Up > Down > Left > Right.
    function automatic logic [N_NAV-1:0] nav_pick(input logic [N_NAV-1:0] pend);
        logic [N_NAV-1:0] pick;
        pick = '0;
        if (pend[BTN_SELECT])     pick[BTN_SELECT] = 1'b1;
        else if (pend[BTN_UP])    pick[BTN_UP]     = 1'b1;
        else if (pend[BTN_DOWN])  pick[BTN_DOWN]   = 1'b1;
        else if (pend[BTN_LEFT])  pick[BTN_LEFT]   = 1'b1;
        else if (pend[BTN_RIGHT]) pick[BTN_RIGHT]  = 1'b1;
        return pick;
    endfunction

endpackage

// File: rtl/memory_btn_debounce.sv
// rtl/memory_btn_debounce.sv - per-button synchroniser, debounce FSM and press event
//
// Purpose: turns one raw asynchronous button level into a debounced level and
//          a single-cycle press event per accepted press.
// Ports:   clk, rst_n (async active-low), btn (raw input),
//          press_evt (one cycle per press), lvl (debounced level).

module memory_btn_debounce
    import memory_btn_pkg::*;
#(
    parameter int DB_CNT = 500000,
    parameter int CNT_W  = $clog2(DB_CNT)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press_evt,
    output logic lvl
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CNT - 1);

    logic [1:0]       sync;
    logic             s2;
    btn_state_t       state;
    logic [CNT_W-1:0] cnt;

    assign s2 = sync[1];

    // press_evt and lvl are registered alongside the state so they track
    // the state the FSM is entering: lvl high in S_PRESS/S_HELD/S_WQ0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync      <= 2'b00;
            state     <= S_IDLE;
            cnt       <= '0;
            press_evt <= 1'b0;
            lvl       <= 1'b0;
        end else begin
            sync      <= {sync[0], btn};
            press_evt <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (s2) begin
                        state <= S_WQ1;
                        cnt   <= '0;
                    end
                end
                S_WQ1: begin
                    if (!s2) begin
                        state <= S_IDLE;
                    end else if (cnt == CNT_MAX) begin
                        state     <= S_PRESS;
                        press_evt <= 1'b1;
                        lvl       <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_PRESS: begin
                    state <= S_HELD;
                end
                S_HELD: begin
                    if (!s2) begin
                        state <= S_WQ0;
                        cnt   <= '0;
                    end
                end
                S_WQ0: begin
                    if (s2) begin
                        state <= S_HELD;
                    end else if (cnt == CNT_MAX) begin
                        state <= S_IDLE;
                        lvl   <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    lvl   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/memory_btn_conditioner.sv
// rtl/memory_btn_conditioner.sv - push-button front-end producing clean pulses for the memory game core
//
// Purpose: debounces seven buttons, passes Start/Ack presses straight through
//          as pulses, and serialises navigation presses through a pending
//          buffer so at most one navigation pulse fires per clock.
// Ports:   Clk, Reset_n (async active-low);
//          Right, Left, Up, Down, Select, Start, Ack (raw buttons);
//          Right_p, Left_p, Up_p, Down_p, Select_p, Start_p, Ack_p (pulses);
//          Btn_lvl[6:0] (debounced levels), Pend[4:0] (pending nav presses).

module memory_btn_conditioner
    import memory_btn_pkg::*;
#(
    parameter int DB_CNT = 500000,
    parameter int CNT_W  = $clog2(DB_CNT)
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Right,
    input  logic       Left,
    input  logic       Up,
    input  logic       Down,
    input  logic       Select,
    input  logic       Start,
    input  logic       Ack,
    output logic       Right_p,
    output logic       Left_p,
    output logic       Up_p,
    output logic       Down_p,
    output logic       Select_p,
    output logic       Start_p,
    output logic       Ack_p,
    output logic [6:0] Btn_lvl,
    output logic [4:0] Pend
);

    logic [N_BTN-1:0] raw;
    logic [N_BTN-1:0] evt;
    logic [N_BTN-1:0] lvl;
    logic [N_NAV-1:0] issue;

    assign raw = {Ack, Start, Select, Down, Up, Left, Right};

    for (genvar i = 0; i < N_BTN; i++) begin : g_db
        memory_btn_debounce #(
            .DB_CNT (DB_CNT),
            .CNT_W  (CNT_W)
        ) u_db (
            .clk       (Clk),
            .rst_n     (Reset_n),
            .btn       (raw[i]),
            .press_evt (evt[i]),
            .lvl       (lvl[i])
        );
    end

    assign Btn_lvl = lvl;
    assign issue   = nav_pick(Pend);

    // A new press on the bit being issued in the same cycle is OR-ed back in
    // after the clear, so it stays pending and issues on a later cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Pend     <= '0;
            Right_p  <= 1'b0;
            Left_p   <= 1'b0;
            Up_p     <= 1'b0;
            Down_p   <= 1'b0;
            Select_p <= 1'b0;
            Start_p  <= 1'b0;
            Ack_p    <= 1'b0;
        end else begin
            Pend     <= (Pend & ~issue) | evt[N_NAV-1:0];
            Right_p  <= issue[BTN_RIGHT];
            Left_p   <= issue[BTN_LEFT];
            Up_p     <= issue[BTN_UP];
            Down_p   <= issue[BTN_DOWN];
            Select_p <= issue[BTN_SELECT];
            Start_p  <= evt[BTN_START];
            Ack_p    <= evt[BTN_ACK];
        end
    end

endmodule

// File: tb/tb_memory_btn_conditioner.sv
// tb/tb_memory_btn_conditioner.sv - directed self-checking bench for memory_btn_conditioner

module tb_memory_btn_conditioner;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       Right, Left, Up, Down, Select, Start, Ack;
    logic       Right_p, Left_p, Up_p, Down_p, Select_p, Start_p, Ack_p;
    logic [6:0] Btn_lvl;
    logic [4:0] Pend;
    logic [6:0] pv;

    int checks   = 0;
    int failures = 0;
    int pcnt [7];
    int base [7];
    int onehot_bad = 0;

    memory_btn_conditioner #(.DB_CNT(4)) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Right    (Right),
        .Left     (Left),
        .Up       (Up),
        .Down     (Down),
        .Select   (Select),
        .Start    (Start),
        .Ack      (Ack),
        .Right_p  (Right_p),
        .Left_p   (Left_p),
        .Up_p     (Up_p),
        .Down_p   (Down_p),
        .Select_p (Select_p),
        .Start_p  (Start_p),
        .Ack_p    (Ack_p),
        .Btn_lvl  (Btn_lvl),
        .Pend     (Pend)
    );

    always #5 Clk = ~Clk;

    assign pv = {Ack_p, Start_p, Select_p, Down_p, Up_p, Left_p, Right_p};

    always @(negedge Clk) begin
        for (int i = 0; i < 7; i++) if (pv[i]) pcnt[i]++;
        if ($countones(pv[4:0]) > 1) onehot_bad++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        for (int i = 0; i < 7; i++) base[i] = pcnt[i];
    endtask

    function automatic int got(input int i);
        return pcnt[i] - base[i];
    endfunction

    initial begin
        for (int i = 0; i < 7; i++) begin
            pcnt[i] = 0;
            base[i] = 0;
        end
        Reset_n = 1'b0;
        {Right, Left, Up, Down, Select, Start, Ack} = '0;
        step(3);
        chk("reset_pulses", {25'd0, pv}, 32'd0);
        chk("reset_lvl", {25'd0, Btn_lvl}, 32'd0);
        chk("reset_pend", {27'd0, Pend}, 32'd0);
        Reset_n = 1'b1;
        step(2);

        // Clean Right press: pulse after edge 9, level held through release.
        snap();
        Right = 1'b1;
        step(7);
        chk("right_lvl_e7", {25'd0, Btn_lvl}, 32'h01);
        step(1);
        chk("right_pend_e8", {27'd0, Pend}, 32'h01);
        chk("right_nopulse_e8", {25'd0, pv}, 32'd0);
        step(1);
        chk("right_pulse_e9", {25'd0, pv}, 32'h01);
        chk("right_pend_e9", {27'd0, Pend}, 32'd0);
        step(1);
        chk("right_pulse_e10", {25'd0, pv}, 32'd0);
        step(10);
        Right = 1'b0;
        step(6);
        chk("right_lvl_rel6", {25'd0, Btn_lvl}, 32'h01);
        step(1);
        chk("right_lvl_rel7", {25'd0, Btn_lvl}, 32'd0);
        step(3);
        chk("right_count", got(0), 32'd1);

        // Short Start glitch, then bouncy Select.
        snap();
        Start = 1'b1;
        step(3);
        Start = 1'b0;
        step(10);
        chk("start_glitch_lvl", {25'd0, Btn_lvl}, 32'd0);
        Select = 1'b1; step(1);
        Select = 1'b0; step(1);
        Select = 1'b1; step(1);
        Select = 1'b0; step(1);
        Select = 1'b1; step(20);
        chk("start_glitch_count", got(5), 32'd0);
        chk("select_bounce_count", got(4), 32'd1);
        Select = 1'b0;
        step(12);

        // Up, Down, Select together: serialised by priority.
        Up = 1'b1; Down = 1'b1; Select = 1'b1;
        step(8);
        chk("tri_lvl_e8", {25'd0, Btn_lvl}, 32'h1C);
        chk("tri_pend_e8", {27'd0, Pend}, 32'h1C);
        chk("tri_pulse_e8", {25'd0, pv}, 32'd0);
        step(1);
        chk("tri_pulse_e9", {25'd0, pv}, 32'h10);
        chk("tri_pend_e9", {27'd0, Pend}, 32'h0C);
        step(1);
        chk("tri_pulse_e10", {25'd0, pv}, 32'h04);
        chk("tri_pend_e10", {27'd0, Pend}, 32'h08);
        step(1);
        chk("tri_pulse_e11", {25'd0, pv}, 32'h08);
        chk("tri_pend_e11", {27'd0, Pend}, 32'd0);
        step(1);
        chk("tri_pulse_e12", {25'd0, pv}, 32'd0);
        Up = 1'b0; Down = 1'b0; Select = 1'b0;
        step(12);

        // Left with bouncy release.
        snap();
        Left = 1'b1;
        step(12);
        Left = 1'b0; step(2);
        Left = 1'b1; step(2);
        Left = 1'b0; step(2);
        step(12);
        chk("left_bounce_count", got(1), 32'd1);
        chk("left_bounce_lvl", {25'd0, Btn_lvl}, 32'd0);

        // Ack and Right together: Ack at edge 8, Right at edge 9.
        Ack = 1'b1; Right = 1'b1;
        step(8);
        chk("ack_right_e8", {25'd0, pv}, 32'h40);
        step(1);
        chk("ack_right_e9", {25'd0, pv}, 32'h01);
        Ack = 1'b0; Right = 1'b0;
        step(12);

        // Reset with Pend=00011 and Down mid-debounce; Down held through.
        snap();
        Right = 1'b1; Left = 1'b1;
        step(3);
        Down = 1'b1;
        step(5);
        chk("rst_pend_before", {27'd0, Pend}, 32'h03);
        Reset_n = 1'b0;
        #1;
        chk("rst_pend_async", {27'd0, Pend}, 32'd0);
        chk("rst_pulse_async", {25'd0, pv}, 32'd0);
        chk("rst_lvl_async", {25'd0, Btn_lvl}, 32'd0);
        Right = 1'b0; Left = 1'b0;
        step(3);
        Reset_n = 1'b1;
        step(8);
        chk("down_nopulse_e8", {25'd0, pv}, 32'd0);
        chk("down_lvl_e8", {25'd0, Btn_lvl}, 32'h08);
        step(1);
        chk("down_pulse_e9", {25'd0, pv}, 32'h08);
        step(10);
        chk("rst_down_count", got(3), 32'd1);
        chk("rst_right_count", got(0), 32'd0);
        chk("rst_left_count", got(1), 32'd0);
        Down = 1'b0;
        step(12);

        chk("nav_onehot", onehot_bad, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
